rob_issue_scheduler: RTL and testbench

Issue scheduler between dispatch and the 4-entry reorder buffer's completion ports. Holds dispatched ops tagged with their ROB index and picks the oldest ready op for a shared 1-cycle ALU and a shared non-pipelined multi-cycle MEM unit. Drives the ROB's alu_complete/mem_complete interfaces. Oldest-first age is taken relative to the ROB head pointer.

---
 rtl/rob_pkg.sv | 24 ++
 rtl/rob_age_picker.sv | 34 +++
 rtl/rob_issue_scheduler.sv | 164 ++++++++++++++++
 tb/tb_rob_issue_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and constants for the ROB issue scheduler: opcode encoding,
// operation-class helper and the default queue/data sizes.
package rob_pkg;

  localparam int ROB_DEPTH = 4;
  localparam int TAG_W     = 2;
  localparam int DW        = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_LD   = 3'd4,
    OP_ST   = 3'd5,
    OP_NOP6 = 3'd6,
    OP_NOP7 = 3'd7
  } opcode_e;

  function automatic logic is_mem_op(input opcode_e op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/rob_age_picker.sv
// Oldest-first selector: among masked entries, picks the one whose tag is
// closest to rob_head going forward (age = tag - head, modulo tag space).
module rob_age_picker #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic [DEPTH-1:0]            mask,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]            head,
  output logic                        found,
  output logic [$clog2(DEPTH)-1:0]    sel
);

  localparam int SEL_W = $clog2(DEPTH);

  logic [TAG_W-1:0] best_age;
  logic [TAG_W-1:0] age;

  always_comb begin
    found    = 1'b0;
    sel      = '0;
    best_age = '1;
    age      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age = tags[i] - head;
      if (mask[i] && (!found || (age < best_age))) begin
        found    = 1'b1;
        sel      = SEL_W'(i);
        best_age = age;
      end
    end
  end

endmodule

// File: rtl/rob_issue_scheduler.sv
// Issue queue feeding a 1-cycle ALU and a non-pipelined MEM unit, oldest-first
// relative to rob_head. Optional dispatch-stall counter under ROB_ISSUE_PERF_EN.
module rob_issue_scheduler
  import rob_pkg::*;
#(
  parameter int DEPTH   = rob_pkg::ROB_DEPTH,
  parameter int DW      = rob_pkg::DW,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          disp_valid,
  output logic          disp_ready,
  input  logic [1:0]    disp_rob_idx,
  input  logic [2:0]    disp_opcode,
  input  logic [DW-1:0] disp_a,
  input  logic [DW-1:0] disp_b,
  input  logic [1:0]    rob_head,
  output logic          alu_complete,
  output logic [1:0]    alu_rob_idx,
  output logic [DW-1:0] alu_result,
  output logic          mem_complete,
  output logic [1:0]    mem_rob_idx,
  output logic [DW-1:0] mem_result,
  output logic          mem_busy,
  output logic [2:0]    iq_count,
  output logic [7:0]    stall_cnt
);

  localparam int SEL_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [2:0] IQ_FULL = 3'(DEPTH);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q;
  opcode_e                     op_q [DEPTH];
  logic [DW-1:0]               a_q  [DEPTH];
  logic [DW-1:0]               b_q  [DEPTH];

  logic                        alu_v_q;
  logic [TAG_W-1:0]            alu_tag_q;
  logic [DW-1:0]               alu_res_q;
  logic [CNT_W-1:0]            mem_cnt_q;
  logic [TAG_W-1:0]            mem_tag_q;
  logic [DW-1:0]               mem_res_q;

  logic [DEPTH-1:0] alu_mask, mem_mask;
  logic             alu_found, mem_found, mem_free, accept, tag_in_use;
  logic [SEL_W-1:0] alu_sel, mem_sel, free_slot;

  function automatic logic [DW-1:0] alu_eval(input opcode_e op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return '0;
    endcase
  endfunction

  // MEM unit accepts a new op in the cycle its previous op completes
  assign mem_free = (mem_cnt_q <= CNT_W'(1));

  always_comb begin
    alu_mask   = '0;
    mem_mask   = '0;
    free_slot  = '0;
    tag_in_use = 1'b0;
    iq_count   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      alu_mask[i] = valid_q[i] && !is_mem_op(op_q[i]);
      mem_mask[i] = valid_q[i] && is_mem_op(op_q[i]) && mem_free;
      if (!valid_q[i]) free_slot = SEL_W'(i);
      if (valid_q[i] && (tag_q[i] == disp_rob_idx)) tag_in_use = 1'b1;
      iq_count = iq_count + 3'(valid_q[i]);
    end
  end

  assign disp_ready = (iq_count != IQ_FULL);
  assign accept     = disp_valid && disp_ready && !flush;

  rob_age_picker #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_alu_pick (
    .mask(alu_mask), .tags(tag_q), .head(rob_head), .found(alu_found), .sel(alu_sel)
  );

  rob_age_picker #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_mem_pick (
    .mask(mem_mask), .tags(tag_q), .head(rob_head), .found(mem_found), .sel(mem_sel)
  );

  always_comb begin
    valid_d = valid_q;
    if (alu_found) valid_d[alu_sel]   = 1'b0;
    if (mem_found) valid_d[mem_sel]   = 1'b0;
    if (accept)    valid_d[free_slot] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      tag_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i] <= OP_ADD;
        a_q[i]  <= '0;
        b_q[i]  <= '0;
      end
      alu_v_q   <= 1'b0;
      alu_tag_q <= '0;
      alu_res_q <= '0;
      mem_cnt_q <= '0;
      mem_tag_q <= '0;
      mem_res_q <= '0;
    end else if (flush) begin
      valid_q   <= '0;
      alu_v_q   <= 1'b0;
      mem_cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        tag_q[free_slot] <= disp_rob_idx;
        op_q[free_slot]  <= opcode_e'(disp_opcode);
        a_q[free_slot]   <= disp_a;
        b_q[free_slot]   <= disp_b;
      end
      alu_v_q <= alu_found;
      if (alu_found) begin
        alu_tag_q <= tag_q[alu_sel];
        alu_res_q <= alu_eval(op_q[alu_sel], a_q[alu_sel], b_q[alu_sel]);
      end
      if (mem_found) begin
        mem_cnt_q <= CNT_W'(MEM_LAT);
        mem_tag_q <= tag_q[mem_sel];
        mem_res_q <= (op_q[mem_sel] == OP_LD) ? DW'(a_q[mem_sel] + b_q[mem_sel]) : '0;
      end else if (mem_cnt_q != '0) begin
        mem_cnt_q <= mem_cnt_q - CNT_W'(1);
      end
    end
  end

  assign alu_complete = alu_v_q;
  assign alu_rob_idx  = alu_tag_q;
  assign alu_result   = alu_res_q;
  assign mem_complete = (mem_cnt_q == CNT_W'(1));
  assign mem_rob_idx  = mem_tag_q;
  assign mem_result   = mem_res_q;
  assign mem_busy     = (mem_cnt_q != '0);

`ifdef ROB_ISSUE_PERF_EN
  logic [7:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else if (disp_valid && !disp_ready && (stall_q != 8'hFF)) stall_q <= stall_q + 8'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  // ROB tags are unique while queued; a duplicate dispatch is a dispatch-stage bug
  a_unique_tag : assert property (@(posedge clk) disable iff (!rst_n)
    (disp_valid && disp_ready && !flush) |-> !tag_in_use);

endmodule

// File: tb/tb_rob_issue_scheduler.sv
// Randomized self-checking bench for rob_issue_scheduler against a queue-based
// reference model; honours ROB_ISSUE_PERF_EN for the stall counter.
module tb_rob_issue_scheduler;

  localparam int MEM_LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       disp_valid = 1'b0;
  logic       disp_ready;
  logic [1:0] disp_rob_idx = '0;
  logic [2:0] disp_opcode = '0;
  logic [2:0] disp_a = '0, disp_b = '0;
  logic [1:0] rob_head = '0;
  logic       alu_complete, mem_complete, mem_busy;
  logic [1:0] alu_rob_idx, mem_rob_idx;
  logic [2:0] alu_result, mem_result, iq_count;
  logic [7:0] stall_cnt;

  rob_issue_scheduler #(.DEPTH(4), .DW(3), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rob_idx(disp_rob_idx),
    .disp_opcode(disp_opcode), .disp_a(disp_a), .disp_b(disp_b), .rob_head(rob_head),
    .alu_complete(alu_complete), .alu_rob_idx(alu_rob_idx), .alu_result(alu_result),
    .mem_complete(mem_complete), .mem_rob_idx(mem_rob_idx), .mem_result(mem_result),
    .mem_busy(mem_busy), .iq_count(iq_count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ops waiting in a queue, plus what each unit is doing.
  typedef struct {int tag; int op; int a; int b;} op_t;
  op_t q[$];
  bit  m_alu_v;
  int  m_alu_tag, m_alu_res;
  int  m_mem_left;
  int  m_mem_tag, m_mem_res;
  int  m_stall;

  function automatic int ref_result(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % 8;
      1: return (a - b + 8) % 8;
      2: return a & b;
      3: return a | b;
      4: return (a + b) % 8;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_mem(input int op);
    return (op == 4) || (op == 5);
  endfunction

  function automatic int age_of(input int tag);
    return (tag - int'(rob_head) + 4) % 4;
  endfunction

  task automatic model_reset();
    q.delete();
    m_alu_v = 0; m_alu_tag = 0; m_alu_res = 0;
    m_mem_left = 0; m_mem_tag = 0; m_mem_res = 0;
    m_stall = 0;
  endtask

  task automatic model_edge();
    bit ready;
    int ai, mi;
    ready = (q.size() < 4);
`ifdef ROB_ISSUE_PERF_EN
    if (disp_valid && !ready && m_stall < 255) m_stall++;
`endif
    if (flush) begin
      q.delete();
      m_alu_v = 0;
      m_mem_left = 0;
      return;
    end
    ai = -1; mi = -1;
    foreach (q[i]) begin
      if (!is_mem(q[i].op)) begin
        if (ai < 0 || age_of(q[i].tag) < age_of(q[ai].tag)) ai = i;
      end else if (m_mem_left <= 1) begin
        if (mi < 0 || age_of(q[i].tag) < age_of(q[mi].tag)) mi = i;
      end
    end
    m_alu_v = (ai >= 0);
    if (ai >= 0) begin
      m_alu_tag = q[ai].tag;
      m_alu_res = ref_result(q[ai].op, q[ai].a, q[ai].b);
    end
    if (mi >= 0) begin
      m_mem_left = MEM_LAT;
      m_mem_tag = q[mi].tag;
      m_mem_res = ref_result(q[mi].op, q[mi].a, q[mi].b);
    end else if (m_mem_left > 0) begin
      m_mem_left--;
    end
    if (ai > mi) begin
      q.delete(ai);
      if (mi >= 0) q.delete(mi);
    end else begin
      if (mi >= 0) q.delete(mi);
      if (ai >= 0) q.delete(ai);
    end
    if (disp_valid && ready)
      q.push_back('{tag: int'(disp_rob_idx), op: int'(disp_opcode), a: int'(disp_a), b: int'(disp_b)});
  endtask

  task automatic check_outputs();
    check_eq("disp_ready", int'(disp_ready), int'(q.size() < 4));
    check_eq("iq_count", int'(iq_count), q.size());
    check_eq("alu_complete", int'(alu_complete), int'(m_alu_v));
    if (m_alu_v) begin
      check_eq("alu_rob_idx", int'(alu_rob_idx), m_alu_tag);
      check_eq("alu_result", int'(alu_result), m_alu_res);
    end
    check_eq("mem_complete", int'(mem_complete), int'(m_mem_left == 1));
    if (m_mem_left == 1) begin
      check_eq("mem_rob_idx", int'(mem_rob_idx), m_mem_tag);
      check_eq("mem_result", int'(mem_result), m_mem_res);
    end
    check_eq("mem_busy", int'(mem_busy), int'(m_mem_left != 0));
    check_eq("stall_cnt", int'(stall_cnt), m_stall);
  endtask

  // One clock: drive inputs just after the edge, check mid-cycle, advance model.
  task automatic cycle(input bit v, input int tag, input int op, input int a, input int b,
                       input bit fl);
    disp_valid   = v;
    disp_rob_idx = 2'(tag);
    disp_opcode  = 3'(op);
    disp_a       = 3'(a);
    disp_b       = 3'(b);
    flush        = fl;
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic int free_tag();
    int cand[$];
    bit used;
    for (int t = 0; t < 4; t++) begin
      used = 0;
      foreach (q[i]) if (q[i].tag == t) used = 1;
      if (!used) cand.push_back(t);
    end
    if (cand.size() == 0) return int'($urandom_range(0, 3));
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    disp_valid = 1'b0;
    flush = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD with wrap, single entry
    rob_head = 2'd0;
    cycle(1, 0, 0, 3, 6, 0);
    idle(3);

    // Age wrap with rob_head=2: tags 2,3,0 each in its own cycle
    rob_head = 2'd2;
    cycle(1, 2, 0, 1, 1, 0);
    cycle(1, 3, 1, 2, 5, 0);
    cycle(1, 0, 3, 4, 1, 0);
    idle(3);

    // Back-to-back loads
    rob_head = 2'd0;
    cycle(1, 1, 4, 5, 4, 0);
    cycle(1, 2, 4, 2, 3, 0);
    idle(6);

    // Fill with MEM ops and keep pushing; also the stall-counter stretch
    for (int i = 0; i < 600; i++) cycle(1, free_tag(), 4 + (i % 2), int'($urandom_range(0, 7)),
                                        int'($urandom_range(0, 7)), 0);
    idle(10);

    // Flush with an ALU pulse pending, MEM in flight and a same-cycle dispatch
    cycle(1, 0, 4, 1, 1, 0);
    cycle(1, 1, 0, 2, 2, 0);
    cycle(1, 2, 2, 7, 3, 1);
    idle(4);

    async_reset();
    idle(2);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) rob_head = 2'($urandom_range(0, 3));
      cycle($urandom_range(0, 3) != 0, free_tag(), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            $urandom_range(0, 39) == 0);
      if (i == 1000) async_reset();
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
